// File: rtl/seg7_pkg.sv
// Shared active-low 7-segment encoding (bit0=a .. bit6=g) used by the display
// driver and by seg7_to_hex_monitor.
package seg7_pkg;

  typedef enum logic [2:0] {
    SEG_BIT_A = 3'd0,
    SEG_BIT_B = 3'd1,
    SEG_BIT_C = 3'd2,
    SEG_BIT_D = 3'd3,
    SEG_BIT_E = 3'd4,
    SEG_BIT_F = 3'd5,
    SEG_BIT_G = 3'd6
  } seg_bit_e;

  localparam logic [6:0] SEG_0     = 7'b100_0000;
  localparam logic [6:0] SEG_1     = 7'b111_1001;
  localparam logic [6:0] SEG_2     = 7'b010_0100;
  localparam logic [6:0] SEG_3     = 7'b011_0000;
  localparam logic [6:0] SEG_4     = 7'b001_1001;
  localparam logic [6:0] SEG_5     = 7'b001_0010;
  localparam logic [6:0] SEG_6     = 7'b000_0010;
  localparam logic [6:0] SEG_7     = 7'b111_1000;
  localparam logic [6:0] SEG_8     = 7'b000_0000;
  localparam logic [6:0] SEG_9     = 7'b001_0000;
  localparam logic [6:0] SEG_A     = 7'b000_1000;
  localparam logic [6:0] SEG_B     = 7'b000_0011;
  localparam logic [6:0] SEG_C     = 7'b100_0110;
  localparam logic [6:0] SEG_D     = 7'b010_0001;
  localparam logic [6:0] SEG_E     = 7'b000_0110;
  localparam logic [6:0] SEG_F     = 7'b000_1110;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] code;
  } seg7_dec_t;

endpackage

// File: rtl/seg7_pattern_to_nibble.sv
// Combinational inverse lookup: active-low segment pattern -> {legal, blank, code}.
module seg7_pattern_to_nibble
  import seg7_pkg::*;
(
  input  logic [6:0] i_pattern,
  output seg7_dec_t  o_dec
);

  always_comb begin
    // NOTE: a full default before the case keeps every path assigned, so no latch is inferred.
    o_dec = '0;
    unique case (i_pattern)
      SEG_0:     o_dec = '{legal: 1'b1, blank: 1'b0, code: 4'h0};
      SEG_1:     o_dec = '{legal: 1'b1, blank: 1'b0, code: 4'h1};
      SEG_2:     o_dec = '{legal: 1'b1, blank: 1'b0, code: 4'h2};
      SEG_3:     o_dec = '{legal: 1'b1, blank: 1'b0, code: 4'h3};
      SEG_4:     o_dec = '{legal: 1'b1, blank: 1'b0, code: 4'h4};
      SEG_5:     o_dec = '{legal: 1'b1, blank: 1'b0, code: 4'h5};
      SEG_6:     o_dec = '{legal: 1'b1, blank: 1'b0, code: 4'h6};
      SEG_7:     o_dec = '{legal: 1'b1, blank: 1'b0, code: 4'h7};
      SEG_8:     o_dec = '{legal: 1'b1, blank: 1'b0, code: 4'h8};
      SEG_9:     o_dec = '{legal: 1'b1, blank: 1'b0, code: 4'h9};
      SEG_A:     o_dec = '{legal: 1'b1, blank: 1'b0, code: 4'hA};
      SEG_B:     o_dec = '{legal: 1'b1, blank: 1'b0, code: 4'hB};
      SEG_C:     o_dec = '{legal: 1'b1, blank: 1'b0, code: 4'hC};
      SEG_D:     o_dec = '{legal: 1'b1, blank: 1'b0, code: 4'hD};
      SEG_E:     o_dec = '{legal: 1'b1, blank: 1'b0, code: 4'hE};
      SEG_F:     o_dec = '{legal: 1'b1, blank: 1'b0, code: 4'hF};
      SEG_BLANK: o_dec = '{legal: 1'b0, blank: 1'b1, code: 4'h0};
      default:   o_dec = '0;
    endcase
  end

endmodule

// File: rtl/seg7_to_hex_monitor.sv
// Recovers hex codes from a multiplexed active-low 7-segment bus with per-digit
// stability qualification. Optional error counter: define SEG7_MON_ERRCNT_EN.
module seg7_to_hex_monitor
  import seg7_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int STABLE_CNT = 3
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic [6:0]            hex_i,
  input  logic [DIGITS-1:0]     dig_sel_i,
  input  logic                  strobe_i,
  output logic [4*DIGITS-1:0]   kod_o,
  output logic [DIGITS-1:0]     valid_o,
  output logic [DIGITS-1:0]     blank_o,
  output logic                  err_o
`ifdef SEG7_MON_ERRCNT_EN
  ,
  output logic [7:0]            err_cnt_o
`endif
);

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CNT);

  logic [6:0]          r_last [DIGITS];
  logic [3:0]          r_cnt  [DIGITS];
  logic [4*DIGITS-1:0] r_kod;
  logic [DIGITS-1:0]   r_valid;
  logic [DIGITS-1:0]   r_blank;
  logic                r_err;

  logic                w_sel_ok;
  logic [DIGITS-1:0]   w_match;
  seg7_dec_t           w_dec;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
  assign w_sel_ok = (dig_sel_i != '0) &&
                    ((dig_sel_i & (dig_sel_i - DIGITS'(1))) == '0);

  always_comb begin
    w_match = '0;
    for (int n = 0; n < DIGITS; n++) begin
      w_match[n] = (hex_i == r_last[n]);
    end
  end

  // On acceptance the bus equals the stored pattern, so hex_i can be decoded directly.
  seg7_pattern_to_nibble u_decode (
    .i_pattern (hex_i),
    .o_dec     (w_dec)
  );

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      // NOTE: the history arrays are only DIGITS entries of flops, so they are reset like any other state.
      for (int n = 0; n < DIGITS; n++) begin
        r_last[n] <= SEG_BLANK;
        r_cnt[n]  <= '0;
      end
      r_kod   <= '0;
      r_valid <= '0;
      r_blank <= '0;
      r_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      r_err <= 1'b0;
      if (strobe_i) begin
        if (!w_sel_ok) begin
          r_err <= 1'b1;
        end else begin
          for (int n = 0; n < DIGITS; n++) begin
            if (dig_sel_i[n]) begin
              if (w_match[n]) begin
                if (r_cnt[n] != CNT_MAX) r_cnt[n] <= r_cnt[n] + 4'd1;
                // Accept only on the transition into CNT_MAX, never while saturated.
                if (r_cnt[n] == CNT_MAX - 4'd1) begin
                  if (w_dec.legal) begin
                    r_kod[4*n +: 4] <= w_dec.code;
                    r_valid[n]      <= 1'b1;
                    r_blank[n]      <= 1'b0;
                  end else if (w_dec.blank) begin
                    r_valid[n] <= 1'b0;
                    r_blank[n] <= 1'b1;
                  end else begin
                    r_valid[n] <= 1'b0;
                    r_blank[n] <= 1'b0;
                    r_err      <= 1'b1;
                  end
                end
              end else begin
                r_last[n] <= hex_i;
                r_cnt[n]  <= 4'd1;
              end
            end
          end
        end
      end
    end
  end

  assign kod_o   = r_kod;
  assign valid_o = r_valid;
  assign blank_o = r_blank;
  assign err_o   = r_err;

`ifdef SEG7_MON_ERRCNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_err_cnt <= '0;
    end else if (r_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt_o = r_err_cnt;
`endif

endmodule
